// File: rtl/led_sequencer.sv
// LED animation sequencer: plays FILL/CHASE/REVFILL/BLINK patterns frame by
// frame, REPEATS passes of N_LEDS+1 frames, each frame TICK_DIV clk cycles.
// Optional feature macro: LED_SEQ_RETRIGGER_EN (start while running restarts).
module led_sequencer #(
  parameter int unsigned N_LEDS   = 5,
  parameter int unsigned TICK_DIV = 16777216,
  parameter int unsigned REPEATS  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  output logic [N_LEDS-1:0] led,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FRAME_W = $clog2(N_LEDS + 1);
  localparam int unsigned PASS_W  = (REPEATS > 1) ? $clog2(REPEATS) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(N_LEDS);
  localparam logic [PASS_W-1:0]  PASS_LAST  = PASS_W'(REPEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state, state_d;
  logic [TICK_W-1:0]   tick_cnt, tick_d;
  logic [FRAME_W-1:0]  frame, frame_d;
  logic [PASS_W-1:0]   pass, pass_d;
  logic [1:0]          mode_q, mode_d;
  logic [N_LEDS-1:0]   led_d;
  logic                busy_d;
  logic                done_d;

  // LED pattern for a given mode and frame; the final frame is always dark
  function automatic logic [N_LEDS-1:0] frame_pattern(input logic [1:0] m,
                                                      input logic [FRAME_W-1:0] f);
    logic [N_LEDS-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      case (m)
        2'd0:    p[i] = (i <= 32'(f));
        2'd1:    p[i] = (i == 32'(f));
        2'd2:    p[i] = ((i + 32'(f)) >= (N_LEDS - 1));
        default: p[i] = ~f[0];
      endcase
    end
    if (f == FRAME_LAST) begin
      p = '0;
    end
    return p;
  endfunction

  // Next-state, counter and output logic
  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    frame_d = frame;
    pass_d  = pass;
    mode_d  = mode_q;
    done_d  = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          tick_d  = '0;
          frame_d = '0;
          pass_d  = '0;
          mode_d  = mode;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          tick_d  = '0;
          frame_d = '0;
          pass_d  = '0;
        end
`ifdef LED_SEQ_RETRIGGER_EN
        else if (start) begin
          tick_d  = '0;
          frame_d = '0;
          pass_d  = '0;
          mode_d  = mode;
        end
`endif
        else if (tick_cnt == TICK_LAST) begin
          tick_d = '0;
          if (frame == FRAME_LAST) begin
            frame_d = '0;
            if (pass == PASS_LAST) begin
              state_d = IDLE;
              pass_d  = '0;
              done_d  = 1'b1;
            end else begin
              pass_d = pass + PASS_W'(1);
            end
          end else begin
            frame_d = frame + FRAME_W'(1);
          end
        end else begin
          tick_d = tick_cnt + TICK_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    led_d  = busy_d ? frame_pattern(mode_d, frame_d) : '0;
  end

  // State, counters and registered outputs; synchronous reset has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      frame    <= '0;
      pass     <= '0;
      mode_q   <= 2'd0;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_d;
      frame    <= frame_d;
      pass     <= pass_d;
      mode_q   <= mode_d;
      led      <= led_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer (N_LEDS=5, TICK_DIV=4, REPEATS=3) plus a
// TICK_DIV=1, REPEATS=1 instance for the fastest-frame corner.
module tb_led_sequencer;

  localparam int N     = 5;
  localparam int TD    = 4;
  localparam int RP    = 3;
  localparam int TOTAL = RP * (N + 1) * TD;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic         busy, done;

  logic         sm_start;
  logic [1:0]   sm_mode;
  logic [N-1:0] sm_led;
  logic         sm_busy, sm_done;

  typedef struct packed {
    logic [N-1:0] led;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_miss = 0;
  int cyc, done_cnt, busy_cnt, last_done;

  bit         m_run;
  int         m_el;
  logic [1:0] m_mode;

  always #5 clk = ~clk;

  led_sequencer #(.N_LEDS(N), .TICK_DIV(TD), .REPEATS(RP)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .led(led), .busy(busy), .done(done)
  );

  led_sequencer #(.N_LEDS(N), .TICK_DIV(1), .REPEATS(1)) u_small (
    .clk(clk), .reset(reset), .start(sm_start), .mode(sm_mode), .abort(1'b0),
    .led(sm_led), .busy(sm_busy), .done(sm_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference pattern computed arithmetically
  function automatic logic [N-1:0] ref_pat(input logic [1:0] m, input int f);
    logic [N-1:0] ones;
    ones = '1;
    if (f >= N) return '0;
    case (m)
      2'd0:    return N'((1 << (f + 1)) - 1);
      2'd1:    return N'(1 << f);
      2'd2:    return ones & ~N'((1 << (N - f - 1)) - 1);
      default: return ((f % 2) == 0) ? ones : '0;
    endcase
  endfunction

  // Drive one cycle, predict via elapsed-time model, compare after the edge
  task automatic step(input logic rst, input logic st, input logic ab, input logic [1:0] md);
    exp_t e;
    bit   fin;
    reset = rst; start = st; abort = ab; mode = md;
    fin = 0;
    if (rst) m_run = 0;
    else if (m_run && ab) m_run = 0;
`ifdef LED_SEQ_RETRIGGER_EN
    else if (m_run && st) begin m_el = 0; m_mode = md; end
`endif
    else if (m_run) begin
      m_el++;
      if (m_el == TOTAL) begin m_run = 0; fin = 1; end
    end
    else if (st && !ab) begin m_run = 1; m_el = 0; m_mode = md; end
    e.led  = m_run ? ref_pat(m_mode, (m_el / TD) % (N + 1)) : '0;
    e.busy = m_run;
    e.done = fin;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("led",  32'(led),  32'(e.led));
    check("busy", 32'(busy), 32'(e.busy));
    check("done", 32'(done), 32'(e.done));
    if (done === 1'b1) begin done_cnt++; last_done = cyc; end
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'($urandom));
  endtask

  task automatic reset_dut();
    step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    cyc = 0; done_cnt = 0; busy_cnt = 0; last_done = -1;
  endtask

  logic [N-1:0] sm_exp_led  [8];
  logic         sm_exp_busy [8];
  logic         sm_exp_done [8];

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
    sm_start = 1'b0; sm_mode = 2'd0;
    m_run = 0; m_el = 0; m_mode = 2'd0;
    cyc = 0;

    // Reset state; abort in idle and abort+start both leave it idle
    reset_dut();
    step(1'b0, 1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 1'b1, 2'd1);
    run_idle(2);

    // FILL full animation
    reset_dut();
    step(1'b0, 1'b1, 1'b0, 2'd0);
    run_idle(79);
    check("fill_done_cycle", 32'(last_done), 32'd73);
    check("fill_busy_cycles", 32'(busy_cnt), 32'd72);
    check("fill_done_count", 32'(done_cnt), 32'd1);

    // CHASE full animation
    reset_dut();
    step(1'b0, 1'b1, 1'b0, 2'd1);
    run_idle(75);
    check("chase_done_cycle", 32'(last_done), 32'd73);

    // BLINK, then reset mid-animation: no done afterwards
    reset_dut();
    step(1'b0, 1'b1, 1'b0, 2'd3);
    run_idle(25);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    check("rst_led", 32'(led), 32'd0);
    run_idle(60);
    check("rst_no_done", 32'(done_cnt), 32'd0);

    // Abort at cycle 10, fresh REVFILL start at cycle 12
    reset_dut();
    step(1'b0, 1'b1, 1'b0, 2'd0);
    run_idle(9);
    step(1'b0, 1'b0, 1'b1, 2'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_idle(1);
    step(1'b0, 1'b1, 1'b0, 2'd2);
    run_idle(75);
    check("abort_restart_done", 32'(last_done), 32'd85);

    // start with mode=1 at cycle 30 during FILL
    reset_dut();
    step(1'b0, 1'b1, 1'b0, 2'd0);
    run_idle(29);
    step(1'b0, 1'b1, 1'b0, 2'd1);
    run_idle(79);
`ifdef LED_SEQ_RETRIGGER_EN
    check("midstart_done_cycle", 32'(last_done), 32'd103);
`else
    check("midstart_done_cycle", 32'(last_done), 32'd73);
`endif

    // start held high: level-sensitive retrigger after done
    reset_dut();
    for (int i = 0; i < 160; i++) step(1'b0, 1'b1, 1'b0, 2'd0);
`ifdef LED_SEQ_RETRIGGER_EN
    check("held_done_count", 32'(done_cnt), 32'd0);
`else
    check("held_done_count", 32'(done_cnt), 32'd2);
    check("held_last_done", 32'(last_done), 32'd146);
`endif

    // TICK_DIV=1, REPEATS=1: one frame per cycle, done at cycle 7
    sm_exp_led  = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000, 5'b00000, 5'b00000};
    sm_exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    sm_exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    reset_dut();
    sm_start = 1'b1;
    step(1'b0, 1'b0, 1'b0, 2'd0);
    sm_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step(1'b0, 1'b0, 1'b0, 2'd0);
      check("small_led",  32'(sm_led),  32'(sm_exp_led[i]));
      check("small_busy", 32'(sm_busy), 32'(sm_exp_busy[i]));
      check("small_done", 32'(sm_done), 32'(sm_exp_done[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter N_LEDS, default 5, number of LED outputs (min 2).
REQ-002 SHALL have parameter TICK_DIV, default 16777216, clk cycles per animation frame (min 1).
REQ-003 SHALL have parameter REPEATS, default 3, full passes per animation (min 1).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  trigger, sampled every clk edge.
REQ-007 SHALL have port mode  input  2  pattern select, latched on accepted start.
REQ-008 SHALL have port abort  input  1  synchronous cancel of a running animation.
REQ-009 SHALL have port led  output  N_LEDS  registered LED pattern.
REQ-010 SHALL have port busy  output  1  high while animation running.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-012 SHALL use a single clock domain; frame timing via internal tick counter 0..TICK_DIV-1 and a tick enable, no derived clocks.
REQ-013 SHALL implement states IDLE and RUN; busy = (state == RUN).
REQ-014 IDLE: start=1 and abort=0 at edge t -> RUN at t+1, frame=0, pass=0, tick counter=0, mode latched, led = frame-0 pattern at t+1.
REQ-015 Each pass SHALL have N_LEDS+1 frames (f = 0..N_LEDS), each held exactly TICK_DIV cycles.
REQ-016 mode 0 FILL: frame f<N_LEDS -> lowest f+1 bits set.
REQ-017 mode 1 CHASE: frame f<N_LEDS -> only bit f set.
REQ-018 mode 2 REVFILL: frame f<N_LEDS -> highest f+1 bits set.
REQ-019 mode 3 BLINK: frame f<N_LEDS -> all ones if f even, all zeros if f odd.
REQ-020 Frame N_LEDS SHALL be all zeros in every mode.
REQ-021 On expiry of frame N_LEDS: pass<REPEATS-1 -> pass+1, frame 0; else -> IDLE, led=0, done=1 for exactly that one cycle.
REQ-022 Total busy duration SHALL be REPEATS*(N_LEDS+1)*TICK_DIV cycles.
REQ-023 abort=1 in RUN -> next cycle IDLE, led=0, busy=0, done stays 0; abort in IDLE has no effect.
REQ-024 abort and start in same cycle -> abort wins, no start accepted.
REQ-025 start held high continuously SHALL re-trigger on the first IDLE cycle after done (level-sensitive).
REQ-026 In IDLE led SHALL be all zeros; mode changes in RUN SHALL have no effect.
REQ-027 Counter widths SHALL be sized via $clog2 of TICK_DIV, N_LEDS+1, REPEATS; no overflow at any legal parameter value.

Reset
REQ-028 reset=1 at edge -> next cycle state IDLE, led=0, busy=0, done=0, all counters 0, regardless of state.
REQ-029 reset SHALL take priority over start and abort; reset mid-animation SHALL produce no done pulse.

Configuration
REQ-030 Macro LED_SEQ_RETRIGGER_EN defined: start=1 (abort=0) in RUN restarts at frame 0, pass 0, tick 0, new mode latched, no done pulse.
REQ-031 LED_SEQ_RETRIGGER_EN undefined: start in RUN SHALL be ignored.

Verification (N_LEDS=5, TICK_DIV=4, REPEATS=3, start pulse at cycle 0)
REQ-032 Reset: assert reset during RUN -> next cycle led=00000, busy=0, done=0; no done afterwards.
REQ-033 FILL: led 00001 cycles 1-4, 00011 5-8, 00111 9-12, 01111 13-16, 11111 17-20, 00000 21-24; repeats; busy 1-72; done=1 only at cycle 73, busy=0 at 73.
REQ-034 CHASE: per-pass frames 00001,00010,00100,01000,10000,00000, 4 cycles each; BLINK: 11111,00000,11111,00000,11111,00000.
REQ-035 Abort at cycle 10 -> cycle 11 led=00000, busy=0; done never asserted; start at 12 begins fresh at frame 0.
REQ-036 start at cycle 30 with mode=1: macro undefined -> FILL continues, done at 73; macro defined -> cycle 31 led=00001 CHASE, done at 103.
REQ-037 TICK_DIV=1, REPEATS=1: FILL frames change every cycle, busy cycles 1-6, done at cycle 7.
